// File: rtl/up_control.sv
// Microsequencer for up_datapath: fetches opcode/operand nibbles over a read
// handshake, drives datapath write enables, and reports busy/halt/fault status.
module up_control #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       start,
  input  logic [3:0] ir,
  input  logic       mem_ack,
  output logic       mem_rd,
  output logic       a_sel_in_a,
  output logic       a_sel_in_b,
  output logic [3:0] a_op,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_inc,
  output logic [1:0] rb_sel_out_a,
  output logic [1:0] rb_sel_out_b,
  output logic [2:0] rb_sel_in,
  output logic       rb_we,
  output logic       sp_we,
  output logic       busy,
  output logic       halted,
  output logic       fault,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FOP   = 3'd1,
    S_DEC   = 3'd2,
    S_FARG  = 3'd3,
    S_EXE   = 3'd4,
    S_LD    = 3'd5,
    S_HALT  = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_B    = 4'h7;

  // Last counter value at which an ack can still be accepted.
  localparam logic [TW-1:0] W_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_opcode;
  logic [3:0]    r_operand;
  logic [TW-1:0] r_wait;

  logic          w_wait_state;
  logic          w_timeout;
  logic [3:0]    w_operand;
  logic [1:0]    w_ra;
  logic [1:0]    w_rb;

  assign w_wait_state = (r_state == S_FOP) || (r_state == S_FARG) || (r_state == S_LD);
  assign w_timeout    = w_wait_state && !mem_ack && (r_wait == W_LAST);

  // The operand nibble sits in the datapath ir during EXE; later states use the latched copy.
  assign w_operand = (r_state == S_EXE) ? ir : r_operand;
  assign w_ra      = w_operand[3:2];
  assign w_rb      = w_operand[1:0];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state   <= S_IDLE;
      r_opcode  <= 4'h0;
      r_operand <= 4'h0;
      r_wait    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DEC) r_opcode <= ir;
      if (r_state == S_EXE) r_operand <= ir;
      if (w_wait_state && !mem_ack) r_wait <= r_wait + TW'(1);
      else                          r_wait <= '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    mem_rd       = 1'b0;
    a_sel_in_a   = 1'b0;
    a_sel_in_b   = 1'b0;
    a_op         = 4'h0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_inc       = 1'b0;
    rb_sel_out_a = 2'b00;
    rb_sel_out_b = 2'b00;
    rb_sel_in    = 3'b000;
    rb_we        = 1'b0;
    sp_we        = 1'b0;
    illegal      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FOP;
      end

      S_FOP: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          ir_we  = 1'b1;
          pc_inc = 1'b1;
          w_next = S_DEC;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end

      S_DEC: begin
        if (ir <= 4'hA) begin
          w_next = S_FARG;
        end else if (ir == OP_NOP) begin
          w_next = S_FOP;
        end else if (ir == OP_HALT) begin
          w_next = S_HALT;
        end else begin
          illegal = 1'b1;
          w_next  = S_FOP;
        end
      end

      S_FARG: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          ir_we  = 1'b1;
          pc_inc = 1'b1;
          w_next = S_EXE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end

      S_EXE: begin
        w_next = S_FOP;
        case (r_opcode)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
            a_sel_in_a   = 1'b1;
            a_sel_in_b   = 1'b1;
            rb_sel_out_a = w_ra;
            rb_sel_out_b = w_rb;
            a_op         = r_opcode;
            rb_we        = 1'b1;
            rb_sel_in    = {1'b1, w_ra};
          end
          4'h7: begin
            a_op         = OP_B;
            a_sel_in_b   = 1'b1;
            rb_sel_out_b = w_rb;
            rb_we        = 1'b1;
            rb_sel_in    = {1'b1, w_ra};
          end
          4'h8: begin
            w_next = S_LD;
          end
          4'h9: begin
            a_op         = OP_B;
            a_sel_in_b   = 1'b1;
            rb_sel_out_b = w_rb;
            pc_we        = 1'b1;
          end
          4'hA: begin
            a_op         = OP_B;
            a_sel_in_b   = 1'b1;
            rb_sel_out_b = w_rb;
            sp_we        = 1'b1;
          end
          default: w_next = S_FOP;
        endcase
      end

      // Immediate load: the data word is written straight from data_in.
      S_LD: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          rb_we     = 1'b1;
          rb_sel_in = {1'b0, r_operand[1:0]};
          pc_inc    = 1'b1;
          w_next    = S_FOP;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end

      S_HALT:  w_next = S_HALT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy   = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_FAULT);
  assign halted = (r_state == S_HALT);
  assign fault  = (r_state == S_FAULT);

endmodule

// File: doc/up_control.md
Name: up_control

Overview:
- Microsequencer FSM that drives the up_datapath control inputs (ALU select and op, ir/pc/sp/reg-block write enables) and the nibble-wide instruction-memory read handshake.
- Executes a fetch-opcode / fetch-operand / execute cycle over 4-bit instructions read back on the datapath `ir` output.
- Reports busy, halt, illegal-opcode and bus-timeout status to the system.

Parameters:
TIMEOUT, 16, max cycles a memory read may wait for mem_ack before FAULT (1..2^TW-1)
TW, 5, width of the wait counter

Ports:
clk  input  1  clock
nRst  input  1  reset, asynchronous, active-low
start  input  1  begin execution from IDLE (level, sampled in IDLE only)
ir  input  4  current instruction nibble from datapath
mem_ack  input  1  memory read data valid on data_in this cycle
mem_rd  output  1  memory read request, held until mem_ack or timeout
a_sel_in_a  output  1  ALU A source: 1=reg-block port A, 0=sp
a_sel_in_b  output  1  ALU B source: 1=reg-block port B, 0=pc
a_op  output  4  ALU operation code
ir_we  output  1  load ir from data_in
pc_we  output  1  load pc from ALU result
pc_inc  output  1  increment pc by one (datapath pc incrementer)
rb_sel_out_a  output  2  reg-block read select A
rb_sel_out_b  output  2  reg-block read select B
rb_sel_in  output  3  reg-block write select ({0,r}=data_in, {1,r}=ALU result)
rb_we  output  1  reg-block write enable
sp_we  output  1  load sp from ALU result
busy  output  1  high in any state other than IDLE, HALT, FAULT
halted  output  1  high in HALT
fault  output  1  high in FAULT
illegal  output  1  one-cycle pulse on decode of opcode 0xC–0xE

Behaviour:
- Reset: state IDLE, opcode reg 0, operand reg 0, wait counter 0. All outputs 0 while nRst low and in IDLE. Reset mid-instruction abandons it with no further writes.
- All control outputs are combinational from state/opcode/operand. Default is 0 for every output not explicitly asserted in a state.
- IDLE: if start=1, go to FOP.
- FOP (fetch opcode):
  - Assert mem_rd.
  - On mem_ack: ir_we=1, pc_inc=1, go to DEC.
- DEC:
  - Latch ir into the opcode reg.
  - Opcodes 0x0–0xA go to FARG.
  - 0xB (NOP) goes to FOP.
  - 0xF goes to HALT.
  - 0xC–0xE: illegal=1 this cycle, then go to FOP (treated as NOP).
- FARG (fetch operand):
  - Assert mem_rd.
  - On mem_ack: ir_we=1, pc_inc=1, go to EXE.
  - In EXE, operand = ir; ra=ir[3:2], rb=ir[1:0].
- EXE (single cycle):
  - 0x0–0x6 (ADD, SUB, MUL, DIV, NAND, NOR, XOR): a_sel_in_a=1, a_sel_in_b=1, rb_sel_out_a=ra, rb_sel_out_b=rb, a_op=opcode, rb_we=1, rb_sel_in={1,ra}. Go to FOP.
  - 0x7 MOV: a_op=7 (B), a_sel_in_b=1, rb_sel_out_b=rb, rb_we=1, rb_sel_in={1,ra}. Go to FOP.
  - 0x8 LDI: no writes. Operand latched. Go to LD.
  - 0x9 JMP: a_op=7, a_sel_in_b=1, rb_sel_out_b=rb, pc_we=1. Go to FOP.
  - 0xA SETSP: a_op=7, a_sel_in_b=1, rb_sel_out_b=rb, sp_we=1. Go to FOP.
- LD:
  - Assert mem_rd.
  - On mem_ack: rb_we=1, rb_sel_in={0,rb}, pc_inc=1, go to FOP.
- HALT: sticky until nRst.
- FAULT: sticky until nRst. All control outputs 0.
- Wait counter:
  - Cleared on entry to FOP/FARG/LD and on every mem_ack.
  - Increments each cycle mem_rd=1 and mem_ack=0.
  - When the counter equals TIMEOUT with no ack, go to FAULT next cycle, with no ir/reg write.
  - An ack arriving on the same cycle the counter reaches TIMEOUT wins; no fault.
- mem_ack while mem_rd=0 is ignored. start outside IDLE is ignored.
- pc_we and pc_inc are never asserted in the same cycle. rb_we is asserted for exactly one cycle per writing instruction.
- Latency:
  - Two-nibble ALU/MOV/JMP/SETSP instruction with zero-wait memory: 4 cycles (FOP, DEC, FARG, EXE).
  - LDI: 5 cycles.
  - NOP, illegal, HALT: 2 cycles to reach the next state.

Test Plan:
1. Reset (r0..r3=1,2,3,4), start, memory returns nibbles 0x0, 0x1 with zero wait -> EXE cycle shows a_op=0, rb_we=1, rb_sel_in=3'b100; r0=3; 4 cycles; busy=1 throughout.
2. LDI r2 (0x8, 0x2, data 0x5A), ack delayed 3 cycles each -> mem_rd held through each wait, rb_sel_in=3'b010 on final ack, r2=0x5A, pc advanced by 3.
3. Opcode 0xD then 0xB -> illegal pulses exactly 1 cycle in DEC, no rb_we/pc_we/sp_we, next fetch proceeds.
4. JMP r3 (0x9, 0x3) -> pc_we=1 with a_op=7, pc=0x04 after EXE; next FOP fetches from 0x04. Then 0xF -> halted=1, mem_rd stays 0 for 20 cycles.
5. TIMEOUT=16, mem_ack never asserted in FARG -> fault=1 on cycle 17 after FARG entry, no ir_we. Ack on exactly cycle 16 -> no fault.
6. nRst asserted during LD wait -> all outputs 0 immediately, state IDLE, r-regs unchanged. start=1 restarts from FOP.
